// File: rtl/stud_audio_fifo_if.sv
// Handshake bundle between the PCM sample source and the modulator-side FIFO.
// Optional port underrun_cnt_o exists only when STUD_AUDIO_FIFO_UNDERRUN_CNT_EN is defined.
interface stud_audio_fifo_if #(
  parameter int AUDIO_WIDTH = 16,
  parameter int ADDR_WIDTH  = 4
);
  logic signed [AUDIO_WIDTH-1:0] wr_data_i;
  logic                          wr_valid_i;
  logic                          wr_ready_o;
  logic                          rd_strobe_i;
  logic signed [AUDIO_WIDTH-1:0] audio_o;
  logic [ADDR_WIDTH:0]           level_o;
  logic                          empty_o;
  logic                          full_o;
  logic                          low_o;
  logic                          underrun_o;
  logic                          clr_underrun_i;
`ifdef STUD_AUDIO_FIFO_UNDERRUN_CNT_EN
  logic [7:0]                    underrun_cnt_o;
`endif

  modport slave (
`ifdef STUD_AUDIO_FIFO_UNDERRUN_CNT_EN
    output underrun_cnt_o,
`endif
    input  wr_data_i, wr_valid_i, rd_strobe_i, clr_underrun_i,
    output wr_ready_o, audio_o, level_o, empty_o, full_o, low_o, underrun_o
  );

  modport master (
`ifdef STUD_AUDIO_FIFO_UNDERRUN_CNT_EN
    input  underrun_cnt_o,
`endif
    output wr_data_i, wr_valid_i, rd_strobe_i, clr_underrun_i,
    input  wr_ready_o, audio_o, level_o, empty_o, full_o, low_o, underrun_o
  );
endinterface

// File: rtl/stud_audio_fifo.sv
// Sample FIFO feeding the delta-sigma modulator: valid/ready writes, strobe-driven registered reads.
// Define STUD_AUDIO_FIFO_UNDERRUN_CNT_EN to add the saturating underrun event counter.
module stud_audio_fifo #(
  parameter int AUDIO_WIDTH = 16,
  parameter int ADDR_WIDTH  = 4,
  parameter int LOW_THRESH  = 4
) (
  input logic              clk_i,
  input logic              rst_i,
  stud_audio_fifo_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LVL_FULL = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] LVL_LOW  = (ADDR_WIDTH+1)'(LOW_THRESH);

  logic signed [AUDIO_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0]         r_wr_ptr;
  logic [ADDR_WIDTH-1:0]         r_rd_ptr;
  logic [ADDR_WIDTH:0]           r_level;
  logic signed [AUDIO_WIDTH-1:0] r_audio;
  logic                          r_underrun;

  logic w_empty;
  logic w_full;
  logic w_wr_en;
  logic w_rd_en;
  logic w_urun_ev;

  assign w_empty   = (r_level == '0);
  assign w_full    = (r_level == LVL_FULL);
  assign w_wr_en   = bus.wr_valid_i & ~w_full;
  assign w_rd_en   = bus.rd_strobe_i & ~w_empty;
  // A strobe on an empty FIFO is an underrun even if a write lands the same edge: no bypass.
  assign w_urun_ev = bus.rd_strobe_i & w_empty;

  assign bus.wr_ready_o = ~w_full;
  assign bus.empty_o    = w_empty;
  assign bus.full_o     = w_full;
  assign bus.low_o      = (r_level < LVL_LOW);
  assign bus.level_o    = r_level;
  assign bus.audio_o    = r_audio;
  assign bus.underrun_o = r_underrun;

  always_ff @(posedge clk_i) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= bus.wr_data_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_audio    <= '0;
      r_underrun <= 1'b0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_en) begin
        r_audio  <= r_mem[r_rd_ptr];
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_wr_en, w_rd_en})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      r_underrun <= w_urun_ev | (r_underrun & ~bus.clr_underrun_i);
    end
  end

`ifdef STUD_AUDIO_FIFO_UNDERRUN_CNT_EN
  // Clear restarts counting, so a coincident event leaves the count at one.
  function automatic logic [7:0] cnt_next(input logic [7:0] cnt, input logic ev, input logic clr);
    logic [7:0] base;
    base = clr ? 8'd0 : cnt;
    if (ev && base != 8'hFF) return base + 8'd1;
    return base;
  endfunction

  logic [7:0] r_urun_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_urun_cnt <= '0;
    else       r_urun_cnt <= cnt_next(r_urun_cnt, w_urun_ev, bus.clr_underrun_i);
  end

  assign bus.underrun_cnt_o = r_urun_cnt;
`endif
endmodule

// File: tb/tb_stud_audio_fifo.sv
// Randomized and directed checks of stud_audio_fifo against a queue-based reference model.
module tb_stud_audio_fifo;
  localparam int AW    = 16;
  localparam int ADW   = 4;
  localparam int DEPTH = 16;
  localparam int LOWT  = 4;

  logic clk = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk = ~clk;

  stud_audio_fifo_if #(.AUDIO_WIDTH(AW), .ADDR_WIDTH(ADW)) bus ();

  stud_audio_fifo #(.AUDIO_WIDTH(AW), .ADDR_WIDTH(ADW), .LOW_THRESH(LOWT)) dut (
    .clk_i (clk),
    .rst_i (rst_i),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic signed [AW-1:0] q[$];
  logic signed [AW-1:0] m_audio;
  logic                 m_urun;
  int                   m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("audio", bus.audio_o, m_audio);
    chk("level", bus.level_o, q.size());
    chk("empty", bus.empty_o, q.size() == 0);
    chk("full", bus.full_o, q.size() == DEPTH);
    chk("low", bus.low_o, q.size() < LOWT);
    chk("ready", bus.wr_ready_o, q.size() != DEPTH);
    chk("underrun", bus.underrun_o, m_urun);
`ifdef STUD_AUDIO_FIFO_UNDERRUN_CNT_EN
    chk("urun_cnt", bus.underrun_cnt_o, m_cnt);
`endif
  endtask

  task automatic model_reset();
    q.delete();
    m_audio = '0;
    m_urun  = 1'b0;
    m_cnt   = 0;
  endtask

  // Called #1 after an edge; drives inputs, advances one clock, updates model, checks.
  task automatic cyc(input logic wv, input logic [AW-1:0] d, input logic st, input logic clr);
    bit was_full, was_empty, ev;
    bus.wr_valid_i     = wv;
    bus.wr_data_i      = d;
    bus.rd_strobe_i    = st;
    bus.clr_underrun_i = clr;
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    @(posedge clk);
    #1;
    ev = st && was_empty;
    if (st && !was_empty) m_audio = q.pop_front();
    if (wv && !was_full) q.push_back(d);
    m_urun = ev ? 1'b1 : (clr ? 1'b0 : m_urun);
    if (clr) m_cnt = ev ? 1 : 0;
    else if (ev && m_cnt < 255) m_cnt = m_cnt + 1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    check_all();
  endtask

  initial begin
    logic signed [AW-1:0] seq [3];
    int bias_w, bias_r;
    seq[0] = 16'h1234;
    seq[1] = 16'h8000;
    seq[2] = 16'h7FFF;
    bus.wr_valid_i = 1'b0;
    bus.wr_data_i = '0;
    bus.rd_strobe_i = 1'b0;
    bus.clr_underrun_i = 1'b0;
    #2;
    do_reset();
    idle(2);
    chk("rst_audio", bus.audio_o, 0);
    chk("rst_empty", bus.empty_o, 1);
    chk("rst_low", bus.low_o, 1);

    // Three known samples out, one clock after each strobe.
    for (int i = 0; i < 3; i++) cyc(1'b1, seq[i], 1'b0, 1'b0);
    chk("lvl3", bus.level_o, 3);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, '0, 1'b1, 1'b0);
      chk("seq_out", bus.audio_o, seq[i]);
      idle(3);
    end
    chk("lvl0", bus.level_o, 0);

    // Fill beyond capacity.
    for (int i = 0; i < 18; i++) cyc(1'b1, AW'($urandom), 1'b0, 1'b0);
    chk("fill_full", bus.full_o, 1);
    chk("fill_ready", bus.wr_ready_o, 0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("pop_lvl", bus.level_o, 15);
    chk("pop_ready", bus.wr_ready_o, 1);
    cyc(1'b1, 16'h5A5A, 1'b0, 1'b0);
    chk("refill_lvl", bus.level_o, 16);

    // Underrun holds last sample.
    do_reset();
    cyc(1'b1, 16'h00A5, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    idle(1);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("urun_hold", bus.audio_o, 16'h00A5);
    chk("urun_set", bus.underrun_o, 1);
    cyc(1'b0, '0, 1'b0, 1'b1);
    chk("urun_clr", bus.underrun_o, 0);
    // Write and strobe together on empty: underrun, write kept.
    cyc(1'b1, 16'h0777, 1'b1, 1'b0);
    chk("nobypass_lvl", bus.level_o, 1);
    chk("nobypass_urun", bus.underrun_o, 1);
    cyc(1'b0, '0, 1'b1, 1'b1);
    chk("clr_vs_pop", bus.underrun_o, 0);
    chk("clr_vs_pop_audio", bus.audio_o, 16'h0777);

    // Steady-state streaming at level 5 across pointer wrap.
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1'b1, AW'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cyc(1'b1, AW'($urandom), 1'b1, 1'b0);
    chk("stream_lvl", bus.level_o, 5);
    chk("stream_urun", bus.underrun_o, 0);

    // Asynchronous reset mid-stream.
    do_reset();
    for (int i = 0; i < 10; i++) cyc(1'b1, AW'($urandom_range(1, 16'h7FFF)), 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("pre_arst_lvl", bus.level_o, 9);
    #3;
    rst_i = 1'b1;
    #1;
    chk("arst_lvl", bus.level_o, 0);
    chk("arst_audio", bus.audio_o, 0);
    chk("arst_empty", bus.empty_o, 1);
    model_reset();
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    check_all();

    // Randomized traffic with shifting write/read bias.
    for (int blk = 0; blk < 15; blk++) begin
      bias_w = $urandom_range(20, 90);
      bias_r = $urandom_range(20, 90);
      for (int i = 0; i < 200; i++)
        cyc($urandom_range(0, 99) < bias_w, AW'($urandom),
            $urandom_range(0, 99) < bias_r, $urandom_range(0, 99) < 4);
    end

`ifdef STUD_AUDIO_FIFO_UNDERRUN_CNT_EN
    // Counter saturation.
    do_reset();
    for (int i = 0; i < 260; i++) cyc(1'b0, '0, 1'b1, 1'b0);
    chk("cnt_sat", bus.underrun_cnt_o, 255);
    cyc(1'b0, '0, 1'b1, 1'b1);
    chk("cnt_clr_ev", bus.underrun_cnt_o, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
